// File: rtl/led_status_ctrl.sv
// Board status-LED controller: 1 ms tick, heartbeat, N stretched activity channels and an
// error-code blink sequencer that overrides them. Optional LED_PWM_EN dims the heartbeat.
module led_status_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int HB_HALF_MS = 1000,
  parameter int N_CH       = 2,
  parameter int STRETCH_MS = 50,
  parameter int ERR_ON_MS  = 200,
  parameter int ERR_OFF_MS = 200,
  parameter int ERR_GAP_MS = 1000,
  parameter int PWM_DUTY   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] act,
  input  logic [3:0]      err_code,
  output logic            led,
  output logic [N_CH-1:0] led_act,
  output logic            hb,
  output logic            err_busy
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HB_W     = (HB_HALF_MS > 1) ? $clog2(HB_HALF_MS) : 1;
  localparam int ST_W     = (STRETCH_MS > 0) ? $clog2(STRETCH_MS + 1) : 1;
  localparam int ERR_MAX  = (ERR_ON_MS > ERR_OFF_MS)
                            ? ((ERR_ON_MS > ERR_GAP_MS) ? ERR_ON_MS : ERR_GAP_MS)
                            : ((ERR_OFF_MS > ERR_GAP_MS) ? ERR_OFF_MS : ERR_GAP_MS);
  localparam int ERR_W    = (ERR_MAX > 1) ? $clog2(ERR_MAX) : 1;

  if (N_CH < 1 || N_CH > 8 || (CLK_HZ % 1000) != 0 || PWM_DUTY < 0 || PWM_DUTY > 256)
  begin : g_bad_param
    $error("led_status_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} err_state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [HB_W-1:0]   hb_cnt;
  logic [ST_W-1:0]   st_cnt [N_CH];
  logic              hb_drive;

  err_state_t        state, state_nxt;
  logic [ERR_W-1:0]  err_ms, err_ms_nxt;
  logic [3:0]        blink_left, blink_nxt;

  // ---------------- 1 ms tick prescaler
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tick_cnt <= '0;
    else if (tick)  tick_cnt <= '0;
    else            tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- heartbeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (tick) begin
      if (hb_cnt == HB_W'(HB_HALF_MS - 1)) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // ---------------- activity stretchers (load wins over a coincident tick)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) st_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (act[i])                         st_cnt[i] <= ST_W'(STRETCH_MS);
        else if (tick && st_cnt[i] != '0)   st_cnt[i] <= st_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    led_act = '0;
    for (int unsigned i = 0; i < N_CH; i++) led_act[i] = (st_cnt[i] != '0);
  end

  // ---------------- error blink sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      err_ms     <= '0;
      blink_left <= '0;
    end else begin
      state      <= state_nxt;
      err_ms     <= err_ms_nxt;
      blink_left <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    err_ms_nxt = err_ms;
    blink_nxt  = blink_left;
    if (state != IDLE && err_code == 4'd0) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (err_code != 4'd0) begin
          blink_nxt  = err_code;
          err_ms_nxt = '0;
          state_nxt  = ON;
        end
        ON: if (tick) begin
          if (err_ms == ERR_W'(ERR_ON_MS - 1)) begin
            err_ms_nxt = '0;
            blink_nxt  = blink_left - 4'd1;
            state_nxt  = (blink_left == 4'd1) ? GAP : OFF;
          end else begin
            err_ms_nxt = err_ms + 1'b1;
          end
        end
        OFF: if (tick) begin
          if (err_ms == ERR_W'(ERR_OFF_MS - 1)) begin
            err_ms_nxt = '0;
            state_nxt  = ON;
          end else begin
            err_ms_nxt = err_ms + 1'b1;
          end
        end
        GAP: if (tick) begin
          if (err_ms == ERR_W'(ERR_GAP_MS - 1)) begin
            err_ms_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            err_ms_nxt = err_ms + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign err_busy = (state != IDLE);

  // ---------------- heartbeat drive and output composition
`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign hb_drive = hb & ({1'b0, pwm_cnt} < 9'(PWM_DUTY));
`else
  assign hb_drive = hb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        led <= 1'b0;
    else if (err_busy) led <= (state == ON);
    else               led <= hb_drive | (|led_act);
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl: timing is predicted from edge counts since reset
// release (ticks every 10th edge) and compared on every cycle.
module tb_led_status_ctrl;

  localparam int TDIV = 10;
  localparam int HB   = 5;
  localparam int ST   = 3;
  localparam int EON  = 2;
  localparam int EOFF = 2;
  localparam int EGAP = 4;

  localparam int P_IDLE = 0, P_ON = 1, P_OFF = 2, P_GAP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] act = '0;
  logic [3:0] err_code = '0;
  logic       led, hb, err_busy;
  logic [1:0] led_act;

  int checks = 0;
  int failures = 0;

  // reference model state
  int c;
  int last_act [2];
  bit seen [2];
  int ph, dl, left;
  bit m_led;

  led_status_ctrl #(
    .CLK_HZ(10000), .HB_HALF_MS(HB), .N_CH(2), .STRETCH_MS(ST),
    .ERR_ON_MS(EON), .ERR_OFF_MS(EOFF), .ERR_GAP_MS(EGAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .act(act), .err_code(err_code),
    .led(led), .led_act(led_act), .hb(hb), .err_busy(err_busy)
  );

  always #5 clk = ~clk;

  function automatic int deadline(input int x, input int n);
    return ((x / TDIV) + n) * TDIV;
  endfunction

  function automatic bit m_hb();
    return (((c / TDIV) / HB) % 2) == 1;
  endfunction

  function automatic logic [1:0] m_act();
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) r[i] = seen[i] && ((c / TDIV - last_act[i] / TDIV) < ST);
    return r;
  endfunction

  function automatic logic [4:0] m_vec();
    return {m_led, m_act(), m_hb(), ph != P_IDLE};
  endfunction

  function automatic logic [4:0] obs();
    return {led, led_act, hb, err_busy};
  endfunction

  task automatic model_reset();
    c = 0; ph = P_IDLE; dl = 0; left = 0; m_led = 1'b0;
    for (int i = 0; i < 2; i++) begin seen[i] = 1'b0; last_act[i] = 0; end
  endtask

  task automatic model_step(input logic [1:0] a, input logic [3:0] e);
    m_led = (ph != P_IDLE) ? (ph == P_ON) : (m_hb() | (|m_act()));
    c++;
    for (int i = 0; i < 2; i++) if (a[i]) begin seen[i] = 1'b1; last_act[i] = c; end
    if (ph != P_IDLE && e == 4'd0) ph = P_IDLE;
    else case (ph)
      P_IDLE: if (e != 4'd0) begin left = e; ph = P_ON; dl = deadline(c, EON); end
      P_ON: if (c == dl) begin
        left--;
        if (left == 0) begin ph = P_GAP; dl = deadline(c, EGAP); end
        else begin ph = P_OFF; dl = deadline(c, EOFF); end
      end
      P_OFF: if (c == dl) begin ph = P_ON; dl = deadline(c, EON); end
      default: if (c == dl) ph = P_IDLE;
    endcase
  endtask

  // drive inputs (called at a falling edge), let the DUT sample them, return at the next falling edge
  task automatic step(input logic [1:0] a, input logic [3:0] e);
    act = a;
    err_code = e;
    @(posedge clk);
    model_step(a, e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== 5'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs(), 5'b0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_heartbeat();
    for (int k = 0; k < 130; k++) begin
      step(2'b00, 4'd0);
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL heartbeat cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
  endtask

  task automatic test_act_pulse();
    int hi;
    hi = 0;
    for (int k = 0; k < 41; k++) begin
      step((k == 0) ? 2'b01 : 2'b00, 4'd0);
      if (led_act[0]) hi++;
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL act_pulse cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
    checks++;
    if (hi < 2 * TDIV + 1 || hi > ST * TDIV) begin
      failures++;
      $display("FAIL act_pulse_width got=%0d cycles exp=21..30", hi);
    end
  endtask

  task automatic test_retrigger();
    int n;
    step(2'b10, 4'd0);
    n = 0;
    while ((c / TDIV - last_act[1] / TDIV) != ST - 1 && n < 100) begin
      step(2'b00, 4'd0);
      n++;
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL retrigger_wait cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL retrigger_timeout got=%0d cycles exp=<100", n);
    end
    for (int k = 0; k < 40; k++) begin
      step((k == 0) ? 2'b10 : 2'b00, 4'd0);
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL retrigger cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
  endtask

  task automatic test_error_seq();
    for (int k = 0; k < 320; k++) begin
      step(2'($urandom_range(0, 3)), 4'd3);
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL error_seq cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
  endtask

  task automatic test_abort_change();
    int n;
    n = 0;
    while (!(ph == P_ON && left == 2) && n < 300) begin
      step(2'b00, 4'd3);
      n++;
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL abort_wait cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL abort_timeout got=%0d cycles exp=<300", n);
    end
    for (int k = 0; k < 5; k++) step(2'b00, 4'd3);
    step(2'b00, 4'd0);
    checks++;
    if (err_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got=%b exp=0", err_busy);
    end
    for (int k = 0; k < 460; k++) begin
      step(2'b00, (k < 20) ? 4'd0 : (k < 60) ? 4'd2 : 4'd5);
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL abort_change cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    logic [1:0] a;
    e = 4'd0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 149) == 0) e = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      a[0] = ($urandom_range(0, 15) == 0);
      a[1] = ($urandom_range(0, 15) == 0);
      step(a, e);
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    step(2'b01, 4'd3);
    while (!(ph == P_ON && m_led && m_hb()) && n < 600) begin
      step(2'b01, 4'd3);
      n++;
    end
    checks++;
    if (n >= 600) begin
      failures++;
      $display("FAIL async_reset_setup got=%0d cycles exp=<600", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs(), 5'b0);
    end
    act = '0;
    err_code = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 60; k++) begin
      step(2'b00, 4'd0);
      checks++;
      if (obs() !== m_vec()) begin
        failures++;
        $display("FAIL after_reset cyc=%0d got=%b exp=%b", c, obs(), m_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_heartbeat();
    test_act_pulse();
    test_retrigger();
    test_error_seq();
    test_abort_change();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
